mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide resource for the pipelined MIPS core; sits in the E stage beside the ALU.
- Sequences MULT/MULTU/DIV/DIVU over fixed latencies and owns the HI/LO registers.
- Generates the md-class stall request consumed by the hazard unit, so D-stage md instructions wait while the unit is occupied.

---
 rtl/mult_div_unit_if.sv | 14 +
 rtl/mult_div_unit.sv | 71 +++++++
 tb/tb_mult_div_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: E-stage request and HI/LO result bundle for the multiply/divide unit
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, md_op, src_a, src_b, d_is_md, input busy, stall_md, hi, lo);
  modport slave  (input start, md_op, src_a, src_b, d_is_md, output busy, stall_md, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency MULT/MULTU/DIV/DIVU sequencer owning HI/LO and the md stall request
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave m
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [31:0] opa, opb, hi, lo;
  logic [1:0]  op;
  logic        is_md;
  logic        sgn, na, nb;
  logic [31:0] ua, ub, dv, uq, ur, quo, rem;
  logic [63:0] prod;
  assign is_md = m.md_op <= 3'd3;
  assign sgn = ~op[0];
  // Sign-extend only for the signed ops so one 64-bit multiply serves both
  assign prod = {{32{sgn & opa[31]}}, opa} * {{32{sgn & opb[31]}}, opb};
  // Divide on magnitudes so INT_MIN / -1 cannot overflow and zero divisors never reach the divider
  assign na  = sgn & opa[31];
  assign nb  = sgn & opb[31];
  assign ua  = na ? -opa : opa;
  assign ub  = nb ? -opb : opb;
  assign dv  = (ub == 32'd0) ? 32'd1 : ub;
  assign uq  = ua / dv;
  assign ur  = ua % dv;
  assign quo = (na ^ nb) ? -uq : uq;
  assign rem = na ? -ur : ur;
  assign m.busy     = state == RUN;
  assign m.stall_md = m.d_is_md & (m.busy | (m.start & is_md));
  assign m.hi = hi;
  assign m.lo = lo;
  always_comb begin
    state_n = (state == IDLE) ? ((m.start && is_md) ? RUN : IDLE) : ((cnt == 4'd1) ? IDLE : RUN);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      opa   <= 32'd0;
      opb   <= 32'd0;
      op    <= 2'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_n;
      if (state == RUN) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (!op[1]) {hi, lo} <= prod;
          else if (opb != 32'd0) begin
            hi <= rem;
            lo <= quo;
          end
        end
      end else if (m.start) begin
        if (is_md) begin
          opa <= m.src_a;
          opb <= m.src_b;
          op  <= m.md_op[1:0];
          cnt <= m.md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (m.md_op == 3'd4) hi <= m.src_a;
        else if (m.md_op == 3'd5) lo <= m.src_a;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of latency, arithmetic, HI/LO moves, stall and async reset
module tb_mult_div_unit;
  logic clk, reset;
  int   n_chk, n_err, n;
  mult_div_unit_if bus ();
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .m(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.md_op = 3'd6;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    bus.d_is_md = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    reset = 1'b0;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    chk("mult cycles", n, 32'd5);
    chk("mult hi", bus.hi, 32'hFFFFFFFF);
    chk("mult lo", bus.lo, 32'hFFFFFFFA);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    chk("multu cycles", n, 32'd5);
    chk("multu hi", bus.hi, 32'hFFFFFFFE);
    chk("multu lo", bus.lo, 32'h00000001);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div cycles", n, 32'd10);
    chk("div hi", bus.hi, 32'hFFFFFFFF);
    chk("div lo", bus.lo, 32'hFFFFFFFD);
    issue(3'd3, 32'd7, 32'd0);
    chk("divz busy", {31'd0, bus.busy}, 32'd1);
    wait_idle(n);
    chk("divz cycles", n, 32'd10);
    chk("divz hi", bus.hi, 32'hFFFFFFFF);
    chk("divz lo", bus.lo, 32'hFFFFFFFD);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("divovf hi", bus.hi, 32'h00000000);
    chk("divovf lo", bus.lo, 32'h80000000);
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu hi", bus.hi, 32'd2);
    chk("divu lo", bus.lo, 32'd14);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = 3'd4;
    bus.src_a = 32'h12345678;
    @(negedge clk);
    chk("mthi hi", bus.hi, 32'h12345678);
    chk("mthi lo", bus.lo, 32'd14);
    chk("mthi busy", {31'd0, bus.busy}, 32'd0);
    bus.md_op = 3'd5;
    bus.src_a = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo lo", bus.lo, 32'h9ABCDEF0);
    chk("mtlo hi", bus.hi, 32'h12345678);
    chk("mtlo busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.d_is_md = 1'b1;
    bus.start = 1'b0;
    #1 chk("stall idle", {31'd0, bus.stall_md}, 32'd0);
    bus.start = 1'b1;
    bus.md_op = 3'd2;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    #1 chk("stall issue", {31'd0, bus.stall_md}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      chk("stall busy", {31'd0, bus.stall_md}, 32'd1);
      n++;
      if (n == 3) begin
        bus.start = 1'b1;
        bus.md_op = 3'd5;
        bus.src_a = 32'hDEADBEEF;
        bus.src_b = 32'd0;
      end else bus.start = 1'b0;
      @(negedge clk);
    end
    chk("stall cycles", n, 32'd10);
    chk("stall after", {31'd0, bus.stall_md}, 32'd0);
    chk("inject hi", bus.hi, 32'd2);
    chk("inject lo", bus.lo, 32'd14);
    bus.d_is_md = 1'b0;
    issue(3'd0, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst hi", bus.hi, 32'd0);
    chk("rst lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("post rst busy", {31'd0, bus.busy}, 32'd0);
    chk("post rst hi", bus.hi, 32'd0);
    chk("post rst lo", bus.lo, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
